// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding and opcode decoding.
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_t;

    localparam int         OPC_HI  = 10;
    localparam int         OPC_LO  = 7;
    localparam logic [3:0] OPC_MVI = 4'b0001;

    // mvi carries an immediate in the following ROM word
    function automatic logic is_mvi(input logic [15:0] iw);
        return (iw[OPC_HI:OPC_LO] == OPC_MVI);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus between the fetch unit, its instruction ROM and the processor it feeds.
interface fetch_unit_if #(
    parameter int AW = 8
);
    logic          Start;
    logic          Stop;
    logic [15:0]   MemData;
    logic          Done;
    logic [AW-1:0] ADDR;
    logic [15:0]   DIN;
    logic          Run;
    logic          Busy;
    logic          Err;
    logic [15:0]   InstrCount;

    modport master (
        input  Start, Stop, MemData, Done,
        output ADDR, DIN, Run, Busy, Err, InstrCount
    );

    modport slave (
        output Start, Stop, MemData, Done,
        input  ADDR, DIN, Run, Busy, Err, InstrCount
    );

endinterface

// File: rtl/fetch_unit_upcount_sat.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module upcount_sat #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    // Count register: clear has priority over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetches instructions from a synchronous ROM, hands them to a processor and
// waits for completion, with a watchdog that latches a fault on a hung processor.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int AW       = 8,
    parameter int WD_LIMIT = 15
) (
    input  logic          Clock,
    input  logic          Resetn,
    fetch_unit_if.master  bus
);

    localparam int             WDW     = (WD_LIMIT < 2) ? 1 : $clog2(WD_LIMIT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'((WD_LIMIT > 0) ? (WD_LIMIT - 1) : 0);

    fetch_state_t  state_r;
    fetch_state_t  state_nxt_s;
    logic [AW-1:0] pc_r;
    logic [AW-1:0] pc_nxt_s;
    logic [AW-1:0] step_s;
    logic [15:0]   iw_r;
    logic [15:0]   iw_nxt_s;
    logic [AW-1:0] addr_r;
    logic [AW-1:0] addr_nxt_s;
    logic          run_r;
    logic          run_nxt_s;
    logic          busy_r;
    logic          busy_nxt_s;
    logic          err_r;
    logic          err_nxt_s;
    logic [15:0]   din_s;
    logic [WDW-1:0] wd_count_s;
    logic [15:0]   instr_count_s;
    logic          start_ok_s;
    logic          wd_clr_s;
    logic          wd_en_s;
    logic          cnt_en_s;

    assign start_ok_s = (state_r == ST_IDLE) && bus.Start && !bus.Stop;
    assign wd_clr_s   = (state_r == ST_ISSUE);
    assign wd_en_s    = (state_r == ST_WAIT) && !bus.Done;
    assign cnt_en_s   = (state_r == ST_WAIT) && bus.Done;

    upcount_sat #(.W(WDW)) u_watchdog (
        .clk   (Clock),
        .rst_n (Resetn),
        .clr   (wd_clr_s),
        .en    (wd_en_s),
        .count (wd_count_s)
    );

    upcount_sat #(.W(16)) u_instr_count (
        .clk   (Clock),
        .rst_n (Resetn),
        .clr   (start_ok_s),
        .en    (cnt_en_s),
        .count (instr_count_s)
    );

    // State, datapath and registered output flops
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_r <= ST_IDLE;
            pc_r    <= '0;
            iw_r    <= 16'h0000;
            addr_r  <= '0;
            run_r   <= 1'b0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            iw_r    <= iw_nxt_s;
            addr_r  <= addr_nxt_s;
            run_r   <= run_nxt_s;
            busy_r  <= busy_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    // Next-state decode; FAULT only exits through reset
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: state_nxt_s = ST_ISSUE;
            ST_ISSUE: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (bus.Done) begin
                    if (bus.Stop) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end else if (wd_count_s >= WD_LAST) begin
                    state_nxt_s = ST_FAULT;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_FAULT: state_nxt_s = ST_FAULT;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // PC and instruction-word updates; PC wraps modulo 2^AW
    always_comb begin
        pc_nxt_s = pc_r;
        iw_nxt_s = iw_r;
        if (is_mvi(iw_r)) begin
            step_s = AW'(2);
        end else begin
            step_s = AW'(1);
        end
        if (start_ok_s) begin
            pc_nxt_s = '0;
        end else if (cnt_en_s) begin
            pc_nxt_s = pc_r + step_s;
        end else begin
            pc_nxt_s = pc_r;
        end
        if (state_r == ST_ISSUE) begin
            iw_nxt_s = bus.MemData;
        end else begin
            iw_nxt_s = iw_r;
        end
    end

    // Outputs decoded from the upcoming state so the flops line up with it
    always_comb begin
        addr_nxt_s = '0;
        run_nxt_s  = 1'b0;
        busy_nxt_s = 1'b0;
        err_nxt_s  = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                addr_nxt_s = '0;
            end
            ST_FETCH: begin
                addr_nxt_s = pc_nxt_s;
                busy_nxt_s = 1'b1;
            end
            ST_ISSUE, ST_WAIT: begin
                addr_nxt_s = pc_nxt_s + AW'(1);
                run_nxt_s  = 1'b1;
                busy_nxt_s = 1'b1;
            end
            ST_FAULT: begin
                busy_nxt_s = 1'b1;
                err_nxt_s  = 1'b1;
            end
            default: begin
                addr_nxt_s = '0;
            end
        endcase
    end

    // ROM data passes straight through while an instruction is outstanding
    always_comb begin
        if ((state_r == ST_ISSUE) || (state_r == ST_WAIT)) begin
            din_s = bus.MemData;
        end else begin
            din_s = 16'h0000;
        end
    end

    assign bus.ADDR       = addr_r;
    assign bus.DIN        = din_s;
    assign bus.Run        = run_r;
    assign bus.Busy       = busy_r;
    assign bus.Err        = err_r;
    assign bus.InstrCount = instr_count_s;

endmodule
